// File: rtl/softmax_argmax_classifier_if.sv
// Score stream and classification result handshake for softmax_argmax_classifier.
// The master side drives the per-class score beats and accepts the result.
// The slave side is the classifier.
interface softmax_argmax_classifier_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  result_ready;
  logic                  result_valid;
  logic [IDX_WIDTH-1:0]  class_idx;
  logic [DATA_WIDTH-1:0] class_score;

  modport master (
    output valid_in, data_in, result_ready,
    input  result_valid, class_idx, class_score
  );

  modport slave (
    input  valid_in, data_in, result_ready,
    output result_valid, class_idx, class_score
  );
endinterface

// File: rtl/softmax_argmax_classifier.sv
// softmax_argmax_classifier: consumes CLASS_NUM serial softmax scores per
// vector, tracks the running maximum and its class index, and presents the
// winning class through a valid/ready handshake.
// Optional feature macro: ARGMAX_TOP2_EN adds runner-up tracking with the
// second_idx and margin outputs.
module softmax_argmax_classifier #(
  parameter int DATA_WIDTH = 32,
  parameter int CLASS_NUM  = 10,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  softmax_argmax_classifier_if.slave bus,
  output logic                   busy,
`ifdef ARGMAX_TOP2_EN
  output logic [IDX_WIDTH-1:0]   second_idx,
  output logic [DATA_WIDTH-1:0]  margin,
`endif
  output logic                   drop_err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CLASS_NUM - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0]  max_idx_q;
  logic [DATA_WIDTH-1:0] nxt_max;
  logic [IDX_WIDTH-1:0]  nxt_idx;

`ifdef ARGMAX_TOP2_EN
  logic [DATA_WIDTH-1:0] second_q;
  logic [IDX_WIDTH-1:0]  second_idx_q;
  logic [DATA_WIDTH-1:0] nxt_second;
  logic [IDX_WIDTH-1:0]  nxt_second_idx;
`endif

  assign busy = (state != IDLE);

  // Running maximum including the current beat; strict compare keeps the earlier index on ties.
  always_comb begin
    nxt_max = max_q;
    nxt_idx = max_idx_q;
    if (bus.data_in > max_q) begin
      nxt_max = bus.data_in;
      nxt_idx = cnt;
    end
  end

`ifdef ARGMAX_TOP2_EN
  // Runner-up including the current beat: a displaced max becomes second, otherwise a strictly larger score replaces it.
  always_comb begin
    nxt_second     = second_q;
    nxt_second_idx = second_idx_q;
    if (bus.data_in > max_q) begin
      nxt_second     = max_q;
      nxt_second_idx = max_idx_q;
    end else if (bus.data_in > second_q) begin
      nxt_second     = bus.data_in;
      nxt_second_idx = cnt;
    end
  end
`endif

  // Vector collection, result presentation and handshake state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      max_q            <= '0;
      max_idx_q        <= '0;
      bus.result_valid <= 1'b0;
      bus.class_idx    <= '0;
      bus.class_score  <= '0;
      drop_err         <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      second_q         <= '0;
      second_idx_q     <= '0;
      second_idx       <= '0;
      margin           <= '0;
`endif
    end else begin
      drop_err <= 1'b0;
      if (flush) begin
        state            <= IDLE;
        cnt              <= '0;
        max_q            <= '0;
        max_idx_q        <= '0;
        bus.result_valid <= 1'b0;
        bus.class_idx    <= '0;
        bus.class_score  <= '0;
`ifdef ARGMAX_TOP2_EN
        second_q         <= '0;
        second_idx_q     <= '0;
        second_idx       <= '0;
        margin           <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (bus.valid_in) begin
              max_q     <= bus.data_in;
              max_idx_q <= '0;
              cnt       <= IDX_WIDTH'(1);
              state     <= COLLECT;
`ifdef ARGMAX_TOP2_EN
              second_q     <= '0;
              second_idx_q <= '0;
`endif
            end
          end
          COLLECT: begin
            if (bus.valid_in) begin
              max_q     <= nxt_max;
              max_idx_q <= nxt_idx;
`ifdef ARGMAX_TOP2_EN
              second_q     <= nxt_second;
              second_idx_q <= nxt_second_idx;
`endif
              if (cnt == LAST_IDX) begin
                state            <= RESULT;
                bus.result_valid <= 1'b1;
                bus.class_idx    <= nxt_idx;
                bus.class_score  <= nxt_max;
`ifdef ARGMAX_TOP2_EN
                second_idx       <= nxt_second_idx;
                margin           <= nxt_max - nxt_second;
`endif
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          RESULT: begin
            if (bus.result_ready) begin
              bus.result_valid <= 1'b0;
              if (bus.valid_in) begin
                max_q     <= bus.data_in;
                max_idx_q <= '0;
                cnt       <= IDX_WIDTH'(1);
                state     <= COLLECT;
`ifdef ARGMAX_TOP2_EN
                second_q     <= '0;
                second_idx_q <= '0;
`endif
              end else begin
                cnt   <= '0;
                state <= IDLE;
              end
            end else if (bus.valid_in) begin
              drop_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_softmax_argmax_classifier.sv
// Self-checking bench for softmax_argmax_classifier: directed scenarios plus
// randomized vectors compared against a whole-vector argmax reference model.
module tb_softmax_argmax_classifier;
  localparam int DW = 32;
  localparam int CN = 10;
  localparam int IW = 4;

  typedef logic [DW-1:0] vec_t [CN];

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  logic drop_err;
`ifdef ARGMAX_TOP2_EN
  logic [IW-1:0] second_idx;
  logic [DW-1:0] margin;
`endif

  int checks = 0;
  int fails  = 0;

  softmax_argmax_classifier_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  softmax_argmax_classifier #(
    .DATA_WIDTH(DW), .CLASS_NUM(CN), .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bus.slave),
    .busy(busy),
`ifdef ARGMAX_TOP2_EN
    .second_idx(second_idx),
    .margin(margin),
`endif
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  // Reference: winner is the first index holding the largest score; runner-up is
  // the largest of the remaining scores (first such index), reported as index 0
  // when that value is 0 because the tracker starts from a zero runner-up.
  function automatic void ref_model(input vec_t v, output int widx, output logic [DW-1:0] wval,
                                    output int sidx, output logic [DW-1:0] sval);
    widx = 0;
    for (int i = 1; i < CN; i++) if (v[i] > v[widx]) widx = i;
    wval = v[widx];
    sval = '0;
    for (int i = 0; i < CN; i++) if (i != widx && v[i] > sval) sval = v[i];
    sidx = 0;
    if (sval != 0) begin
      for (int i = CN - 1; i >= 0; i--) if (i != widx && v[i] == sval) sidx = i;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vector(input vec_t v, input int gap_max);
    for (int i = 0; i < CN; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = v[i];
      tick();
      bus.valid_in = 1'b0;
      if (i < CN - 1) repeat ($urandom_range(gap_max, 0)) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.result_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %0b exp 0", bus.result_valid); end
    checks++; if (bus.class_idx !== '0) begin fails++; $display("[TB] FAIL reset_idx got %0d exp 0", bus.class_idx); end
    checks++; if (bus.class_score !== '0) begin fails++; $display("[TB] FAIL reset_score got %0d exp 0", bus.class_score); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (drop_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_drop got %0b exp 0", drop_err); end
  endtask

  // Directed vector sent back-to-back; the result must appear right after beat 10.
  task automatic test_basic();
    vec_t v = '{32'd5, 32'd9, 32'd3, 32'd12, 32'd7, 32'd1, 32'd0, 32'd2, 32'd8, 32'd4};
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle_busy got %0b exp 0", busy); end
    send_vector(v, 0);
    checks++; if (bus.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid got %0b exp 1", bus.result_valid); end
    checks++; if (bus.class_idx !== 4'd3) begin fails++; $display("[TB] FAIL basic_idx got %0d exp 3", bus.class_idx); end
    checks++; if (bus.class_score !== 32'd12) begin fails++; $display("[TB] FAIL basic_score got %0d exp 12", bus.class_score); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy got %0b exp 1", busy); end
`ifdef ARGMAX_TOP2_EN
    checks++; if (second_idx !== 4'd1) begin fails++; $display("[TB] FAIL basic_second got %0d exp 1", second_idx); end
    checks++; if (margin !== 32'd3) begin fails++; $display("[TB] FAIL basic_margin got %0d exp 3", margin); end
`endif
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
    checks++; if (bus.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_accept got %0b exp 0", bus.result_valid); end
  endtask

  // All-equal scores with single-cycle gaps; the tie must go to index 0.
  task automatic test_ties_gaps();
    for (int i = 0; i < CN; i++) begin
      bus.valid_in = 1'b1; bus.data_in = 32'd100; tick();
      bus.valid_in = 1'b0;
      if (i < CN - 1) begin
        tick();
        checks++; if (bus.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL ties_early_valid beat %0d got 1 exp 0", i); end
      end
    end
    checks++; if (bus.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL ties_valid got %0b exp 1", bus.result_valid); end
    checks++; if (bus.class_idx !== 4'd0) begin fails++; $display("[TB] FAIL ties_idx got %0d exp 0", bus.class_idx); end
    checks++; if (bus.class_score !== 32'd100) begin fails++; $display("[TB] FAIL ties_score got %0d exp 100", bus.class_score); end
  endtask

  // Result held under back-pressure; a beat in the second stall cycle is dropped.
  task automatic test_backpressure();
    for (int c = 0; c < 5; c++) begin
      bus.valid_in = (c == 1); bus.data_in = 32'd999;
      tick();
      bus.valid_in = 1'b0;
      checks++; if (bus.result_valid !== 1'b1 || bus.class_idx !== 4'd0 || bus.class_score !== 32'd100)
        begin fails++; $display("[TB] FAIL bp_hold c%0d got v%0b i%0d s%0d exp v1 i0 s100", c, bus.result_valid, bus.class_idx, bus.class_score); end
      checks++; if (drop_err !== (c == 1)) begin fails++; $display("[TB] FAIL bp_drop c%0d got %0b exp %0b", c, drop_err, (c == 1)); end
    end
    tick();
    checks++; if (drop_err !== 1'b0) begin fails++; $display("[TB] FAIL bp_drop_after got %0b exp 0", drop_err); end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
    checks++; if (bus.result_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_accept got v%0b busy%0b exp v0 busy0", bus.result_valid, busy); end
  endtask

  // Acceptance cycle carries the first beat of the next vector.
  task automatic test_accept_overlap();
    vec_t v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    send_vector(v, 0);
    checks++; if (bus.class_idx !== 4'd9 || bus.class_score !== 32'd10) begin fails++; $display("[TB] FAIL ovl_first got i%0d s%0d exp i9 s10", bus.class_idx, bus.class_score); end
    bus.result_ready = 1'b1; bus.valid_in = 1'b1; bus.data_in = 32'hFFFF_FFFF;
    tick();
    bus.result_ready = 1'b0; bus.valid_in = 1'b0;
    checks++; if (drop_err !== 1'b0 || bus.result_valid !== 1'b0 || busy !== 1'b1)
      begin fails++; $display("[TB] FAIL ovl_accept got drop%0b v%0b busy%0b exp drop0 v0 busy1", drop_err, bus.result_valid, busy); end
    for (int i = 0; i < CN - 1; i++) begin
      bus.valid_in = 1'b1; bus.data_in = '0; tick();
    end
    bus.valid_in = 1'b0;
    checks++; if (bus.result_valid !== 1'b1 || bus.class_idx !== 4'd0 || bus.class_score !== 32'hFFFF_FFFF)
      begin fails++; $display("[TB] FAIL ovl_result got v%0b i%0d s%0h exp v1 i0 sffffffff", bus.result_valid, bus.class_idx, bus.class_score); end
`ifdef ARGMAX_TOP2_EN
    checks++; if (second_idx !== 4'd0 || margin !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL ovl_top2 got i%0d m%0h exp i0 mffffffff", second_idx, margin); end
`endif
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
  endtask

  // Flush mid-vector, then a fresh vector whose maximum sits in the last slot.
  task automatic test_flush();
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      bus.valid_in = 1'b1; bus.data_in = 32'd200 + i; tick();
    end
    flush = 1'b1; bus.valid_in = 1'b1; bus.data_in = 32'd999;
    tick();
    flush = 1'b0; bus.valid_in = 1'b0;
    checks++; if (busy !== 1'b0 || drop_err !== 1'b0 || bus.result_valid !== 1'b0 || bus.class_idx !== '0 || bus.class_score !== '0)
      begin fails++; $display("[TB] FAIL flush_clear got busy%0b drop%0b v%0b i%0d s%0d exp all 0", busy, drop_err, bus.result_valid, bus.class_idx, bus.class_score); end
    for (int i = 0; i < CN - 1; i++) v[i] = DW'($urandom_range(49, 0));
    v[CN-1] = 32'd50;
    send_vector(v, 1);
    checks++; if (bus.result_valid !== 1'b1 || bus.class_idx !== 4'd9 || bus.class_score !== 32'd50)
      begin fails++; $display("[TB] FAIL flush_fresh got v%0b i%0d s%0d exp v1 i9 s50", bus.result_valid, bus.class_idx, bus.class_score); end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
  endtask

  // Asynchronous reset mid-vector clears outputs before the next edge.
  task automatic test_async_reset();
    vec_t v = '{32'd3, 32'd1, 32'd4, 32'd1, 32'd5, 32'd9, 32'd2, 32'd6, 32'd5, 32'd3};
    for (int i = 0; i < 6; i++) begin
      bus.valid_in = 1'b1; bus.data_in = 32'd77; tick();
    end
    bus.valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.class_idx !== '0 || bus.class_score !== '0 || drop_err !== 1'b0)
      begin fails++; $display("[TB] FAIL arst_clear got busy%0b v%0b i%0d s%0d drop%0b exp all 0", busy, bus.result_valid, bus.class_idx, bus.class_score, drop_err); end
    tick();
    rst = 1'b0;
    send_vector(v, 0);
    checks++; if (bus.result_valid !== 1'b1 || bus.class_idx !== 4'd5 || bus.class_score !== 32'd9)
      begin fails++; $display("[TB] FAIL arst_next got v%0b i%0d s%0d exp v1 i5 s9", bus.result_valid, bus.class_idx, bus.class_score); end
    bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
  endtask

  // Random vectors (narrow ranges force ties) with random gaps and stalls.
  task automatic test_random();
    vec_t v;
    int widx, sidx;
    logic [DW-1:0] wval, sval;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < CN; i++)
        v[i] = (n % 2 == 0) ? DW'($urandom_range(7, 0)) : DW'($urandom());
      ref_model(v, widx, wval, sidx, sval);
      send_vector(v, 2);
      repeat ($urandom_range(3, 0)) tick();
      checks++; if (bus.result_valid !== 1'b1 || bus.class_idx !== IW'(widx) || bus.class_score !== wval)
        begin fails++; $display("[TB] FAIL rand_%0d got v%0b i%0d s%0h exp v1 i%0d s%0h", n, bus.result_valid, bus.class_idx, bus.class_score, widx, wval); end
`ifdef ARGMAX_TOP2_EN
      checks++; if (second_idx !== IW'(sidx) || margin !== (wval - sval))
        begin fails++; $display("[TB] FAIL rand_top2_%0d got i%0d m%0h exp i%0d m%0h", n, second_idx, margin, sidx, wval - sval); end
`endif
      bus.result_ready = 1'b1; tick(); bus.result_ready = 1'b0;
      checks++; if (bus.result_valid !== 1'b0 || busy !== 1'b0)
        begin fails++; $display("[TB] FAIL rand_accept_%0d got v%0b busy%0b exp v0 busy0", n, bus.result_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_gaps();
    test_backpressure();
    test_accept_overlap();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
